lfsr_word_packer: RTL and testbench

LFSR_WORD_PACKER -- requirements
Module: lfsr_word_packer

---
 rtl/lfsr_word_packer.sv | 151 +++++++++++++++
 tb/tb_lfsr_word_packer.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_word_packer.sv
// Serial-to-parallel packer: shifts LFSR bits MSB-first into words and queues them in a FIFO.
// Optional von Neumann debiaser ahead of the shifter when PACKER_VN_DEBIAS_EN is defined.
module lfsr_word_packer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     bit_in,
    input  logic                     bit_valid,
    output logic [WIDTH-1:0]         word_out,
    output logic                     word_valid,
    input  logic                     word_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    input  logic                     overflow_clr
);

    localparam int CW  = $clog2(WIDTH);
    localparam int AW  = $clog2(DEPTH);
    localparam int CNW = AW + 1;

    logic             sh_en;
    logic             sh_bit;

`ifdef PACKER_VN_DEBIAS_EN
    logic phase_q, phase_d;
    logic first_q, first_d;

    // A pair forwards its first bit only when the two bits differ.
    always_comb begin
        phase_d = phase_q;
        first_d = first_q;
        sh_en   = 1'b0;
        sh_bit  = first_q;
        if (bit_valid) begin
            phase_d = ~phase_q;
            if (!phase_q) begin
                first_d = bit_in;
            end else begin
                sh_en = first_q ^ bit_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q <= 1'b0;
            first_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
            first_q <= first_d;
        end
    end
`else
    always_comb begin
        sh_en  = bit_valid;
        sh_bit = bit_in;
    end
`endif

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] new_word;
    logic             push;

    always_comb begin
        cnt_d    = cnt_q;
        sr_d     = sr_q;
        push     = 1'b0;
        new_word = {sr_q[WIDTH-2:0], sh_bit};
        if (sh_en) begin
            if (cnt_q == CW'(WIDTH - 1)) begin
                push  = 1'b1;
                cnt_d = '0;
                sr_d  = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
                sr_d  = new_word;
            end
        end
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNW-1:0]   count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             empty;
    logic             full;
    logic             pop;
    logic             wr_en;
    logic             drop;

    // When full, a simultaneous pop frees the head slot the push lands in.
    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == CNW'(DEPTH));
        pop      = !empty && word_ready;
        wr_en    = push && (!full || pop);
        drop     = push && full && !pop;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = new_word;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (wr_en && !pop) begin
            count_d = count_q + CNW'(1);
        end else if (!wr_en && pop) begin
            count_d = count_q - CNW'(1);
        end
        ovf_d = drop || (ovf_q && !overflow_clr);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            sr_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            cnt_q    <= cnt_d;
            sr_q     <= sr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            mem_q    <= mem_d;
        end
    end

    always_comb begin
        word_valid = !empty;
        word_out   = empty ? '0 : mem_q[rd_ptr_q];
        fifo_count = count_q;
        overflow   = ovf_q;
    end

endmodule

// File: tb/tb_lfsr_word_packer.sv
// Bench for lfsr_word_packer: randomized traffic against a queue-based word model.
// Debias scenarios compile in when PACKER_VN_DEBIAS_EN is defined.
module tb_lfsr_word_packer;

    localparam int W = 8;
    localparam int D = 4;
`ifdef PACKER_VN_DEBIAS_EN
    localparam bit DEBIAS = 1'b1;
`else
    localparam bit DEBIAS = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           bit_in;
    logic           bit_valid;
    logic [W-1:0]   word_out;
    logic           word_valid;
    logic           word_ready;
    logic [$clog2(D):0] fifo_count;
    logic           overflow;
    logic           overflow_clr;

    lfsr_word_packer #(.WIDTH(W), .DEPTH(D)) dut (
        .clk          (clk),
        .rst          (rst),
        .bit_in       (bit_in),
        .bit_valid    (bit_valid),
        .word_out     (word_out),
        .word_valid   (word_valid),
        .word_ready   (word_ready),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [W-1:0] m_q[$];
    logic [W-1:0] exp_pop[$];
    logic [W-1:0] got_pop[$];
    int m_part;
    int m_nbits;
    bit m_phase;
    bit m_first;
    bit m_ovf;

    task automatic model_reset();
        m_q.delete();
        exp_pop.delete();
        got_pop.delete();
        m_part  = 0;
        m_nbits = 0;
        m_phase = 0;
        m_first = 0;
        m_ovf   = 0;
    endtask

    task automatic model_edge(input bit bv, input bit b, input bit rdy, input bit clr);
        bit fwd = 0;
        bit fb = 0;
        bit push = 0;
        bit set = 0;
        bit pop;
        logic [W-1:0] w = '0;
        pop = (m_q.size() != 0) && rdy;
        if (bv) begin
            if (DEBIAS) begin
                if (!m_phase) begin
                    m_first = b;
                    m_phase = 1;
                end else begin
                    m_phase = 0;
                    if (m_first != b) begin
                        fwd = 1;
                        fb  = m_first;
                    end
                end
            end else begin
                fwd = 1;
                fb  = b;
            end
        end
        if (fwd) begin
            m_part = (m_part * 2 + int'(fb)) % (1 << W);
            m_nbits++;
            if (m_nbits == W) begin
                push    = 1;
                w       = W'(m_part);
                m_part  = 0;
                m_nbits = 0;
            end
        end
        if (pop) exp_pop.push_back(m_q.pop_front());
        if (push) begin
            if (m_q.size() < D) m_q.push_back(w);
            else set = 1;
        end
        m_ovf = set | (m_ovf & !clr);
    endtask

    // Called at a falling edge; leaves at the next falling edge.
    task automatic cycle(input bit bv, input bit b, input bit rdy, input bit clr);
        bit_valid    = bv;
        bit_in       = b;
        word_ready   = rdy;
        overflow_clr = clr;
        #1;
        if (word_valid && word_ready) got_pop.push_back(word_out);
        @(posedge clk);
        model_edge(bv, b, rdy, clr);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst          = 1'b0;
        bit_valid    = 1'b0;
        bit_in       = 1'b0;
        word_ready   = 1'b0;
        overflow_clr = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic send_word(input logic [W-1:0] w, input bit rdy_all,
                             input bit rdy_last, input int maxgap, input bit clr);
        bit bits[$];
        for (int i = W - 1; i >= 0; i--) begin
            bits.push_back(w[i]);
            if (DEBIAS) bits.push_back(!w[i]);
        end
        for (int k = 0; k < bits.size(); k++) begin
            repeat ($urandom_range(maxgap, 0)) cycle(0, 1'($urandom % 2), rdy_all, clr);
            cycle(1, bits[k], (k == bits.size() - 1) ? rdy_last : rdy_all, clr);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        repeat (3) cycle(1, 1'($urandom % 2), 0, 0);
        send_word(8'h3C, 0, 0, 0, 0);
        repeat (3) cycle(1, 1'($urandom % 2), 0, 0);
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            bit_valid  = 1'b1;
            bit_in     = 1'($urandom % 2);
            word_ready = 1'b1;
            #1;
            total++;
            if ({word_valid, overflow, fifo_count, word_out} !== '0) begin
                bad++;
                $display("FAIL reset_outputs v=%b o=%b c=%0d w=%h want all 0",
                         word_valid, overflow, fifo_count, word_out);
            end
            @(negedge clk);
        end
        bit_valid  = 1'b0;
        word_ready = 1'b0;
        model_reset();
        rst = 1'b1;
        send_word(8'h96, 0, 0, 0, 0);
        repeat (2) cycle(0, 0, 0, 0);
        total++;
        if (fifo_count !== 3'd1) begin
            bad++;
            $display("FAIL reset_one_word count=%0d want 1", fifo_count);
        end
        total++;
        if (word_valid !== 1'b1 || word_out !== 8'h96) begin
            bad++;
            $display("FAIL reset_word v=%b w=%h want 1 96", word_valid, word_out);
        end
    endtask

    task automatic test_b3();
        apply_reset();
        send_word(8'hB3, 1, 1, 0, 0);
        total++;
        if (word_valid !== 1'b1 || word_out !== 8'hB3) begin
            bad++;
            $display("FAIL b3_latency v=%b w=%h want 1 b3", word_valid, word_out);
        end
        cycle(0, 0, 1, 0);
        total++;
        if (word_valid !== 1'b0 || word_out !== 8'h00) begin
            bad++;
            $display("FAIL b3_one_cycle v=%b w=%h want 0 00", word_valid, word_out);
        end
        total++;
        if (got_pop.size() != 1 || got_pop[0] !== 8'hB3) begin
            bad++;
            $display("FAIL b3_popped n=%0d want 1 word b3", got_pop.size());
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int i = 1; i <= 5; i++) send_word(W'(i), 0, 0, 0, 0);
        total++;
        if (fifo_count !== 3'd4 || overflow !== 1'b1) begin
            bad++;
            $display("FAIL ovf_full count=%0d ovf=%b want 4 1", fifo_count, overflow);
        end
        total++;
        if (word_out !== 8'h01) begin
            bad++;
            $display("FAIL ovf_head w=%h want 01", word_out);
        end
        send_word(8'h06, 0, 0, 0, 1);
        total++;
        if (overflow !== 1'b1 || fifo_count !== 3'd4) begin
            bad++;
            $display("FAIL ovf_set_wins ovf=%b count=%0d want 1 4", overflow, fifo_count);
        end
        repeat (6) cycle(0, 0, 1, 0);
        total++;
        if (got_pop.size() != 4 || word_valid !== 1'b0 || fifo_count !== 3'd0) begin
            bad++;
            $display("FAIL ovf_drain n=%0d v=%b want 4 0", got_pop.size(), word_valid);
        end
        for (int i = 0; i < got_pop.size() && i < 4; i++) begin
            total++;
            if (got_pop[i] !== W'(i + 1)) begin
                bad++;
                $display("FAIL ovf_order idx=%0d got=%h want=%h", i, got_pop[i], i + 1);
            end
        end
        total++;
        if (overflow !== 1'b1) begin
            bad++;
            $display("FAIL ovf_sticky ovf=%b want 1", overflow);
        end
        cycle(0, 0, 0, 1);
        total++;
        if (overflow !== 1'b0) begin
            bad++;
            $display("FAIL ovf_clear ovf=%b want 0", overflow);
        end
    endtask

    task automatic test_full_pushpop();
        apply_reset();
        for (int i = 1; i <= 4; i++) send_word(W'(i), 0, 0, 0, 0);
        send_word(8'h05, 0, 1, 0, 0);
        total++;
        if (fifo_count !== 3'd4 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL full_pp count=%0d ovf=%b want 4 0", fifo_count, overflow);
        end
        repeat (6) cycle(0, 0, 1, 0);
        total++;
        if (got_pop.size() != 5) begin
            bad++;
            $display("FAIL full_pp_n n=%0d want 5", got_pop.size());
        end
        for (int i = 0; i < got_pop.size() && i < 5; i++) begin
            total++;
            if (got_pop[i] !== W'(i + 1)) begin
                bad++;
                $display("FAIL full_pp_order idx=%0d got=%h want=%h", i, got_pop[i], i + 1);
            end
        end
    endtask

    task automatic test_gap_reset();
        for (int r = 0; r < 3; r++) begin
            apply_reset();
            repeat (3) cycle(1, 1'($urandom % 2), 1, 0);
            rst = 1'b0;
            @(negedge clk);
            model_reset();
            rst = 1'b1;
            send_word(8'hA5, 1, 1, 3, 0);
            repeat (2) cycle(0, 1'($urandom % 2), 1, 0);
            total++;
            if (got_pop.size() != 1 || got_pop[0] !== 8'hA5 || word_valid !== 1'b0) begin
                bad++;
                $display("FAIL gap_reset run=%0d n=%0d first=%h want 1 a5",
                         r, got_pop.size(), got_pop.size() ? got_pop[0] : 8'h00);
            end
        end
    endtask

    task automatic test_random();
        int errs = 0;
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            bit rdy;
            rdy = ((c / 250) % 2 == 0) ? ($urandom % 8 == 0) : ($urandom % 3 != 0);
            cycle(1'($urandom % 4 != 0), 1'($urandom % 2), rdy, 1'($urandom % 32 == 0));
            total++;
            if (word_valid !== (m_q.size() != 0) ||
                word_out !== (m_q.size() ? m_q[0] : 8'h00) ||
                fifo_count !== 3'(m_q.size()) || overflow !== m_ovf) begin
                bad++;
                errs++;
                if (errs < 10)
                    $display("FAIL rand c=%0d v=%b w=%h n=%0d o=%b want %b %h %0d %b",
                             c, word_valid, word_out, fifo_count, overflow,
                             m_q.size() != 0, m_q.size() ? m_q[0] : 8'h00,
                             m_q.size(), m_ovf);
            end
        end
        total++;
        if (got_pop != exp_pop) begin
            bad++;
            $display("FAIL rand_stream n=%0d want n=%0d", got_pop.size(), exp_pop.size());
        end
    endtask

`ifdef PACKER_VN_DEBIAS_EN
    task automatic test_debias();
        bit pat[8] = '{0, 1, 1, 0, 0, 0, 1, 1};
        apply_reset();
        repeat (4) for (int k = 0; k < 8; k++) cycle(1, pat[k], 0, 0);
        total++;
        if (fifo_count !== 3'd1 || word_out !== 8'h55) begin
            bad++;
            $display("FAIL debias_55 count=%0d w=%h want 1 55", fifo_count, word_out);
        end
        repeat (4) for (int k = 4; k < 8; k++) cycle(1, pat[k], 0, 0);
        total++;
        if (fifo_count !== 3'd1) begin
            bad++;
            $display("FAIL debias_discard count=%0d want 1", fifo_count);
        end
    endtask
`endif

    initial begin
        rst          = 1'b0;
        bit_valid    = 1'b0;
        bit_in       = 1'b0;
        word_ready   = 1'b0;
        overflow_clr = 1'b0;
        @(negedge clk);
        test_reset();
        test_b3();
        test_overflow();
        test_full_pushpop();
        test_gap_reset();
`ifdef PACKER_VN_DEBIAS_EN
        test_debias();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
